// File: rtl/vedic_mul_pkg.sv
// Shared constants and state encoding for the sequenced vedic multiplier front end.
package vedic_mul_pkg;
  localparam int OPW = 64;
  localparam int PRW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic           found_s;
  logic [IDW-1:0] idx_s;

  // First requester at or after last_grant+1 wins.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      idx_s   = (!found_s && req[(int'(last_grant) + k) % NREQ]) ?
                IDW'((int'(last_grant) + k) % NREQ) : idx_s;
      found_s = found_s | req[(int'(last_grant) + k) % NREQ];
    end
    if (found_s) begin
      grant = ONE_HOT0 << idx_s;
    end else begin
      grant = {NREQ{1'b0}};
    end
    grant_idx = idx_s;
    any       = found_s;
  end
endmodule

// File: rtl/vedic_64x64.sv
// Combinational unsigned 64x64 -> 128 multiplier built from four 32x32 vertical/crosswise partial products.
module vedic_64x64
  import vedic_mul_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PRW-1:0] c
);
  logic [63:0] pp_ll_s;
  logic [63:0] pp_lh_s;
  logic [63:0] pp_hl_s;
  logic [63:0] pp_hh_s;

  assign pp_ll_s = {32'd0, a[31:0]}  * {32'd0, b[31:0]};
  assign pp_lh_s = {32'd0, a[31:0]}  * {32'd0, b[63:32]};
  assign pp_hl_s = {32'd0, a[63:32]} * {32'd0, b[31:0]};
  assign pp_hh_s = {32'd0, a[63:32]} * {32'd0, b[63:32]};

  // Vertical terms concatenate; crosswise terms land at bit 32.
  assign c = {pp_hh_s, pp_ll_s} + {32'd0, pp_lh_s, 32'd0} + {32'd0, pp_hl_s, 32'd0};
endmodule

// File: rtl/vedic_mul_arbiter.sv
// Shared, sequenced front end for one vedic_64x64: round-robin issue, multicycle hold, valid/ready response.
module vedic_mul_arbiter
  import vedic_mul_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PRW-1:0]      rsp_c,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);
  localparam int             CW        = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_INIT  = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  state_t          state_r;
  logic [OPW-1:0]  op_a_r;
  logic [OPW-1:0]  op_b_r;
  logic [IDW-1:0]  id_r;
  logic [IDW-1:0]  last_grant_r;
  logic [CW-1:0]   cnt_r;
  logic [PRW-1:0]  rsp_c_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [NREQ-1:0] arb_grant_s;
  logic [IDW-1:0]  arb_idx_s;
  logic            arb_any_s;
  logic [PRW-1:0]  mul_c_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .any        (arb_any_s)
  );

  // op_a_r/op_b_r -> mul_c_s is timed as a MUL_CYCLES multicycle path.
  vedic_64x64 u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .c (mul_c_s)
  );

  // Grants are only visible while idle; the other outputs decode the state register.
  always_comb begin
    if (state_r == IDLE) begin
      req_ready = arb_grant_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
    rsp_valid = (state_r == RESP);
    busy      = (state_r != IDLE);
    rsp_c     = rsp_c_r;
    rsp_id    = rsp_id_r;
  end

  // Issue / multicycle hold / response sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      op_a_r       <= {OPW{1'b0}};
      op_b_r       <= {OPW{1'b0}};
      id_r         <= {IDW{1'b0}};
      last_grant_r <= LAST_INIT;
      cnt_r        <= CNT_ZERO;
      rsp_c_r      <= {PRW{1'b0}};
      rsp_id_r     <= {IDW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_any_s) begin
            op_a_r       <= req_a[int'(arb_idx_s)*OPW +: OPW];
            op_b_r       <= req_b[int'(arb_idx_s)*OPW +: OPW];
            id_r         <= arb_idx_s;
            last_grant_r <= arb_idx_s;
            cnt_r        <= CNT_INIT;
            state_r      <= MUL;
          end
        end
        MUL: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            rsp_c_r  <= mul_c_s;
            rsp_id_r <= id_r;
            state_r  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Self-checking bench: vector table, scoreboard monitor and hand-written multi-cycle sequences.
module tb_vedic_mul_arbiter;
  localparam int NREQ = 4;
  localparam int MC   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [255:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, busy;
  logic [127:0] rsp_c;
  logic [1:0]   rsp_id;

  logic [3:0]   r4_valid, r4_ready;
  logic [255:0] r4_a, r4_b;
  logic         r4_rsp_valid, r4_rsp_ready, r4_busy;
  logic [127:0] r4_rsp_c;
  logic [1:0]   r4_rsp_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]   id;
    logic [127:0] c;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0]   id;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] c;
  } vec_t;
  vec_t tbl[8];

  vedic_mul_arbiter #(.NREQ(NREQ), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_id(rsp_id), .busy(busy)
  );

  vedic_mul_arbiter #(.NREQ(NREQ), .MUL_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(r4_valid), .req_ready(r4_ready),
    .req_a(r4_a), .req_b(r4_b), .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready),
    .rsp_c(r4_rsp_c), .rsp_id(r4_rsp_id), .busy(r4_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, required event never seen", name);
  endtask

  // Monitor: scoreboard push on accept, pop on response, plus per-cycle protocol checks.
  initial begin
    logic         hold_v;
    logic [127:0] hold_c;
    logic [1:0]   hold_id;
    logic         prev_valid;
    int           acc_cyc;
    exp_t         e;
    hold_v = 1'b0; prev_valid = 1'b0; acc_cyc = 0; hold_c = '0; hold_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        hold_v     = 1'b0;
        prev_valid = 1'b0;
      end else begin
        chk("ready_onehot", $onehot0(req_ready), 1'b1);
        if (rsp_valid) chk("no_grant_in_resp", req_ready, 4'b0000);
        if (rsp_valid && hold_v) begin
          chk("hold_c", rsp_c, hold_c);
          chk("hold_id", rsp_id, hold_id);
        end
        if (rsp_valid && !prev_valid) chk("latency", cyc - acc_cyc, MC + 1);
        hold_v     = rsp_valid && !rsp_ready;
        hold_c     = rsp_c;
        hold_id    = rsp_id;
        prev_valid = rsp_valid;
        if (|(req_ready & req_valid)) begin
          for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) begin
              e.id = 2'(i);
              e.c  = {64'd0, req_a[i*64 +: 64]} * {64'd0, req_b[i*64 +: 64]};
              sb_q.push_back(e);
            end
          end
          acc_cyc = cyc;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            timeout_fail("sb_unexpected_rsp");
          end else begin
            e = sb_q.pop_front();
            chk("sb_c", rsp_c, e.c);
            chk("sb_id", rsp_id, e.id);
          end
        end
      end
    end
  end

  task automatic wait_ready(input int idx);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[idx]) ok = 1'b1;
    end
    if (!ok) timeout_fail("wait_ready");
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) timeout_fail("wait_rsp");
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) ok = 1'b1;
    end
    if (!ok) timeout_fail("drain");
  endtask

  initial begin
    logic ok;
    tbl[0] = '{2'd2, 64'd3, 64'd5, 128'd15};
    tbl[1] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    tbl[2] = '{2'd1, 64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000};
    tbl[3] = '{2'd3, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 128'd0};
    tbl[4] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};
    tbl[5] = '{2'd3, 64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000};
    tbl[6] = '{2'd2, 64'd1000000, 64'd1000000, 128'd1000000000000};
    tbl[7] = '{2'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    r4_valid = '0; r4_a = '0; r4_b = '0; r4_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_c", rsp_c, 128'd0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst4_busy", r4_busy, 1'b0);
    rst = 1'b0;

    // Table-driven single operations.
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      req_a[int'(tbl[t].id)*64 +: 64] = tbl[t].a;
      req_b[int'(tbl[t].id)*64 +: 64] = tbl[t].b;
      req_valid = 4'b0001 << tbl[t].id;
      wait_ready(int'(tbl[t].id));
      @(posedge clk); #1;
      req_valid = '0;
      wait_rsp(ok);
      if (ok) begin
        chk("tbl_c", rsp_c, tbl[t].c);
        chk("tbl_id", rsp_id, tbl[t].id);
      end
    end
    drain();

    // All requesters valid from reset: rotation 0,1,2,3,0,1.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*64 +: 64] = {$urandom, $urandom};
      req_b[i*64 +: 64] = {$urandom, $urandom};
    end
    req_valid = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(ok);
      if (ok) chk("rr_id", rsp_id, k % 4);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // Backpressure in RESP with another requester waiting.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_a[64 +: 64] = 64'h1234; req_b[64 +: 64] = 64'h10;
    req_a[192 +: 64] = 64'd5;   req_b[192 +: 64] = 64'd6;
    req_valid = 4'b0010;
    wait_ready(1);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_rsp(ok);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_c", rsp_c, 128'h12340);
      chk("bp_id", rsp_id, 2'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_busy", busy, 1'b0);
    chk("bp_release_grant", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset mid-MUL aborts the op and restores requester 0 priority.
    @(posedge clk); #1;
    req_a[0 +: 64] = 64'd11; req_b[0 +: 64] = 64'd13;
    req_valid = 4'b0001;
    wait_ready(0);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_c", rsp_c, 128'd0);
    chk("abort_req_ready", req_ready, 4'b0000);
    req_valid = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_prio0", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_ready(1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // MUL_CYCLES=4 build: latency and operand isolation.
    @(posedge clk); #1;
    r4_a[0 +: 64] = 64'd7; r4_b[0 +: 64] = 64'd9;
    r4_valid = 4'b0001;
    @(negedge clk);
    chk("mc4_grant", r4_ready, 4'b0001);
    @(posedge clk); #1;
    r4_a[0 +: 64] = 64'd100;
    r4_b[0 +: 64] = 64'd100;
    r4_valid = '0;
    chk("mc4_busy", r4_busy, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("mc4_valid", r4_rsp_valid, k == 4);
    end
    chk("mc4_c", r4_rsp_c, 128'd63);
    chk("mc4_id", r4_rsp_id, 2'd0);
    @(posedge clk); #1;
    chk("mc4_idle", r4_busy, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
